// File: rtl/fib_sequencer.sv
// fib_sequencer: turns the start/step push-buttons into a qualified term
// counter (1..N_MAX) for the Fibonacci register-file datapath.
// Free-run and single-step modes, abort via clr, restart after DONE.
// Optional build macro FIB_SEQ_DEBOUNCE_EN adds a DB_CYCLES stability
// filter on each synchronized button before edge detection.
module fib_sequencer #(
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned N_MAX     = 32,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             step_mode,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             adv,
  output logic             busy,
  output logic             done
);

  // Elaboration-time parameter legality checks
  if ((N_MAX < 2) || (N_MAX > ((2 ** CNT_W) - 1))) begin : g_bad_n_max
    $error("fib_sequencer: N_MAX out of range for CNT_W");
  end
  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("fib_sequencer: DB_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Bit 0 carries start, bit 1 carries step throughout the button path
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] btn_lvl;
  logic [1:0] btn_prev_q;
  logic [1:0] btn_pulse;
  logic       start_p;
  logic       step_p;

  // Two-flop synchronizer for both raw buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {step, start};
      sync2_q <= sync1_q;
    end
  end

`ifdef FIB_SEQ_DEBOUNCE_EN
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]           flt_q;
  logic [1:0][DB_W-1:0] db_cnt_q;

  // Filtered level follows the synchronized input only after it has
  // disagreed for DB_CYCLES consecutive cycles; any agreement resets the run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != flt_q[i]) begin
          if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
            flt_q[i]    <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign btn_lvl = flt_q;
`else
  assign btn_lvl = sync2_q;
`endif

  // Previous-level flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev_q <= '0;
    end else begin
      btn_prev_q <= btn_lvl;
    end
  end

  assign btn_pulse = btn_lvl & ~btn_prev_q;
  assign start_p   = btn_pulse[0];
  assign step_p    = btn_pulse[1];

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             adv_q;
  logic             busy_q;
  logic             done_q;
  logic             at_max;

  assign at_max = (cnt_q == CNT_W'(N_MAX));

  // Sequencer FSM; busy/done are registered alongside every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      adv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!clr && start_p) begin
            cnt_q   <= CNT_W'(1);
            adv_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= step_mode ? S_PAUSE : S_RUN;
          end
        end
        S_RUN: begin
          if (clr) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (at_max) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (step_mode) begin
            state_q <= S_PAUSE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            adv_q <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (clr) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (at_max) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (!step_mode) begin
            state_q <= S_RUN;
          end else if (step_p) begin
            cnt_q <= cnt_q + CNT_W'(1);
            adv_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (clr) begin
            cnt_q   <= '0;
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (start_p) begin
            cnt_q   <= CNT_W'(1);
            adv_q   <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= step_mode ? S_PAUSE : S_RUN;
          end
        end
        default: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cnt  = cnt_q;
  assign adv  = adv_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed bench for fib_sequencer with N_MAX=8 (DB_CYCLES=4 when the
// debounce macro is defined).
module tb_fib_sequencer;

  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             step;
  logic             step_mode;
  logic             clr;
  logic [CNT_W-1:0] cnt;
  logic             adv;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  fib_sequencer #(
    .CNT_W    (CNT_W),
    .N_MAX    (8),
    .DB_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .step     (step),
    .step_mode(step_mode),
    .clr      (clr),
    .cnt      (cnt),
    .adv      (adv),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int c, input int a, input int b, input int d);
    chk({tag, "_cnt"},  32'(cnt),  32'(c));
    chk({tag, "_adv"},  32'(adv),  32'(a));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_done"}, 32'(done), 32'(d));
  endtask

  // Advance n rising edges, leaving time 1 unit after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle press of start; returns one edge after the press
  task automatic press_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    step      = 1'b0;
    step_mode = 1'b0;
    clr       = 1'b0;
    #2;
    outs("reset", 0, 0, 0, 0);
    tick(2);
    rst = 1'b0;
    tick(1);

`ifdef FIB_SEQ_DEBOUNCE_EN
    begin
      int adv_seen;
      adv_seen = 0;
      start = 1'b1;
      tick(2);
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick(1);
        if (adv) adv_seen++;
      end
      chk("glitch_adv", 32'(adv_seen), 0);
      chk("glitch_cnt", 32'(cnt), 0);
      start = 1'b1;
      tick(6);
      outs("db_pre", 0, 0, 0, 0);
      tick(1);
      outs("db_start", 1, 1, 1, 0);
      tick(1);
      outs("db_run", 2, 1, 1, 0);
      tick(4);
      start = 1'b0;
    end
`else
    // Free-run from reset with start held
    start = 1'b1;
    tick(3);
    outs("start", 1, 1, 1, 0);
    for (int i = 2; i <= 8; i++) begin
      tick(1);
      chk("run_cnt", 32'(cnt), 32'(i));
      chk("run_adv", 32'(adv), 1);
    end
    tick(1);
    outs("done", 8, 0, 0, 1);
    tick(3);
    outs("hold", 8, 0, 0, 1);
    start = 1'b0;
    tick(2);

    // Restart from DONE; a start press mid-run is ignored
    press_start();
    tick(2);
    outs("restart", 1, 1, 1, 0);
    tick(2);
    chk("restart_cnt3", 32'(cnt), 3);
    press_start();
    chk("restart_cnt4", 32'(cnt), 4);
    for (int i = 5; i <= 8; i++) begin
      tick(1);
      chk("ign_cnt", 32'(cnt), 32'(i));
      chk("ign_adv", 32'(adv), 1);
    end
    tick(1);
    outs("redone", 8, 0, 0, 1);

    // step in DONE is ignored
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(4);
    outs("step_in_done", 8, 0, 0, 1);

    // Abort at cnt=5, then clr together with a start pulse
    press_start();
    tick(2);
    chk("abort_cnt1", 32'(cnt), 1);
    tick(4);
    chk("abort_cnt5", 32'(cnt), 5);
    clr = 1'b1;
    tick(1);
    outs("abort", 0, 0, 0, 0);
    press_start();
    tick(2);
    outs("clr_start", 0, 0, 0, 0);
    clr = 1'b0;
    tick(4);
    outs("start_lost", 0, 0, 0, 0);

    // Single-step mode
    step_mode = 1'b1;
    press_start();
    tick(2);
    outs("pause_start", 1, 1, 1, 0);
    tick(1);
    outs("pause_hold", 1, 0, 1, 0);
    for (int p = 2; p <= 3; p++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(2);
      chk("step_cnt", 32'(cnt), 32'(p));
      chk("step_adv", 32'(adv), 1);
      tick(1);
      chk("step_cnt_hold", 32'(cnt), 32'(p));
      chk("step_adv_low", 32'(adv), 0);
    end
    step = 1'b1;
    tick(3);
    outs("step4", 4, 1, 1, 0);
    tick(5);
    outs("step_held", 4, 0, 1, 0);
    step = 1'b0;
    tick(2);
    outs("step_rel", 4, 0, 1, 0);

    // Mode switches cost one idle cycle each way
    step_mode = 1'b0;
    tick(1);
    outs("to_run", 4, 0, 1, 0);
    tick(1);
    outs("run5", 5, 1, 1, 0);
    step_mode = 1'b1;
    tick(1);
    outs("to_pause", 5, 0, 1, 0);
    tick(1);
    outs("paused", 5, 0, 1, 0);
    step_mode = 1'b0;
    tick(1);
    outs("to_run2", 5, 0, 1, 0);
    tick(1);
    outs("run6", 6, 1, 1, 0);
    tick(2);
    outs("run8", 8, 1, 1, 0);
    tick(1);
    outs("done2", 8, 0, 0, 1);

    // Asynchronous reset mid-cycle at cnt=6
    press_start();
    tick(2);
    chk("ar_cnt1", 32'(cnt), 1);
    tick(5);
    chk("ar_cnt6", 32'(cnt), 6);
    #3;
    rst = 1'b1;
    #1;
    outs("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(3);
    outs("post_rst", 0, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fib_sequencer.md
# fib_sequencer

Front-end sequencer for the Fibonacci register-file lab datapath. It sits directly upstream of the address/write-enable control stage and drives its `cnt` input. It turns the start and step push-buttons into a clean term counter, starting at `1` and ending at `N_MAX`. Each counter change is qualified with a one-cycle `adv` strobe. It supports free-run and single-step modes, abort, and restart after completion.

## Interface
- `CNT_W`, 6: width of `cnt`.
- `N_MAX`, 32: last term index. Legal range is 2 to 2^CNT_W−1.
- `DB_CYCLES`, 16: debounce stability length in cycles. Used only with `FIB_SEQ_DEBOUNCE_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  raw button; its rising edge starts or restarts a sequence.
- `step`  in  1  raw button; its rising edge advances one term in step mode.
- `step_mode`  in  1  level, synchronous to `clk`; 1 = single-step, 0 = free-run.
- `clr`  in  1  level, synchronous to `clk`; abort to IDLE.
- `cnt`  out  CNT_W  current term index; 0 while idle.
- `adv`  out  1  high for exactly the one cycle in which `cnt` holds a newly advanced value.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  high in DONE.

## Operation
- `start` and `step` each pass through a 2-FF synchronizer and a rising-edge detector (`s2 & ~s3`). This produces one-cycle pulses `start_p` and `step_p`.
- The FSM has four states: IDLE, RUN, PAUSE, DONE. It is one-hot or binary; this is not observable.
- Per-state priority, highest first: `clr`, then `cnt==N_MAX`, then `step_mode`, then advance.
- **IDLE:**
  - `cnt` = 0.
  - On `start_p` (and `clr`=0): `cnt`←1 and `adv`←1.
  - Next state is PAUSE if `step_mode`=1, otherwise RUN.
- **RUN:**
  - `clr` → IDLE with `cnt`←0.
  - Else if `cnt==N_MAX` → DONE, no advance.
  - Else if `step_mode`=1 → PAUSE, no advance.
  - Else `cnt`←`cnt`+1 and `adv`←1 every cycle.
- **PAUSE:**
  - `clr` → IDLE with `cnt`←0.
  - Else if `cnt==N_MAX` → DONE.
  - Else if `step_mode`=0 → RUN, no advance this cycle.
  - Else on `step_p`: `cnt`←`cnt`+1 and `adv`←1.
- **DONE:**
  - `cnt` holds `N_MAX`.
  - `clr` → IDLE.
  - `start_p` → `cnt`←1, `adv`←1, then RUN or PAUSE per `step_mode`.
- `start_p` in RUN or PAUSE is ignored; there is no mid-sequence restart.
- `step_p` in RUN, IDLE or DONE is ignored.
- `cnt` never exceeds `N_MAX` and never wraps. Arithmetic is unsigned CNT_W-bit.
- `busy` and `done` are decoded from the registered state, so they are glitch-free.

## Timing
- **Reset values:** `cnt`=0, `adv`=0, `busy`=0, `done`=0, state IDLE, all synchronizer and debounce flops 0.
- **Reset mid-operation:** asserting `rst` forces the reset values immediately, with no clock needed. Release is synchronous to the next `clk` edge.
- **Start latency:** `start` first sampled high at edge k → `cnt`=1 and `adv`=1 after edge k+2. The same latency applies from `step` to the advance.
- **Free-run:** `cnt` runs 1,2,…,N_MAX on consecutive cycles with `adv` high throughout. `done` rises one cycle after `cnt` reaches `N_MAX`. `adv` is low in that cycle.
- **Mode switch:** changing `step_mode` costs one cycle with no advance (the RUN↔PAUSE transition cycle).
- **Same-cycle `clr` and `start_p`:** `clr` wins and the block stays or returns to IDLE. The start edge is lost.
- **Button held:** produces one pulse only. A new pulse needs a release and re-press; the release must be seen by the synchronizer for at least one cycle.

## Configuration
- **`FIB_SEQ_DEBOUNCE_EN` defined:**
  - Each synchronized button feeds a DB_CYCLES-length stability counter.
  - The filtered level changes only after the synchronized input differs from it for DB_CYCLES consecutive cycles.
  - Edge detection uses the filtered level.
  - Latency grows by DB_CYCLES cycles.
  - Bounces shorter than DB_CYCLES produce no pulse.
- **Undefined:** synchronizer plus edge detector only. No counters are instantiated, and `DB_CYCLES` is unused.

## Test plan
All scenarios use N_MAX=8 and the macro undefined unless stated.
- **Reset, then start:** `rst` pulse, then `start` high from edge 0 → `cnt`=1 after edge 2, then 2..8 on consecutive cycles, `adv` high for 8 cycles, `done`=1 and `busy`=0 one cycle after `cnt`=8; `cnt` holds 8.
- **Step mode:** `step_mode`=1, start, then three `step` presses → `cnt` 1→2→3→4, each with a single `adv` cycle; `cnt` stays 4 while `step` is held.
- **Abort:** `clr` asserted at `cnt`=5 in RUN → `cnt`=0 and `busy`=0 next cycle; `clr` and `start_p` in the same cycle → stays IDLE.
- **Restart from DONE:** `start` pressed in DONE → `cnt` 1..8 again; `start` pressed in RUN at `cnt`=3 → ignored, sequence continues to 8.
- **Async reset:** `rst` asserted mid-cycle at `cnt`=6 → all outputs 0 before the next `clk` edge.
- **With `FIB_SEQ_DEBOUNCE_EN`, DB_CYCLES=4:** a 2-cycle `start` glitch → no `adv`; `start` held 10 cycles → `cnt`=1 after edge 6.
